// File: rtl/v_vram_responder_if.sv
// VRAM port between the vector core (master) and the memory-side responder (slave).
// Carries one read channel and one bit-masked write channel, both without back-pressure.
interface v_vram_responder_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16
);
    logic              vram_r_ena;
    logic [ADDR_W-1:0] vram_r_addr;
    logic [DATA_W-1:0] vram_r_data;
    logic              vram_r_valid;
    logic              vram_w_ena;
    logic [ADDR_W-1:0] vram_w_addr;
    logic [DATA_W-1:0] vram_w_data;
    logic [DATA_W-1:0] vram_w_mask;

    modport master (
        output vram_r_ena, vram_r_addr,
        output vram_w_ena, vram_w_addr, vram_w_data, vram_w_mask,
        input  vram_r_data, vram_r_valid
    );

    modport slave (
        input  vram_r_ena, vram_r_addr,
        input  vram_w_ena, vram_w_addr, vram_w_data, vram_w_mask,
        output vram_r_data, vram_r_valid
    );
endinterface

// File: rtl/v_vram_responder.sv
// VRAM responder: bit-masked writes, fixed-latency reads with valid strobe,
// sticky out-of-range flag and saturating read/write access counters.
module v_vram_responder #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    v_vram_responder_if.slave    vram,
    output logic                 err_oob,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     wr_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              r_in_range_s;
    logic              w_in_range_s;
    logic [IDX_W-1:0]  r_idx_s;
    logic [IDX_W-1:0]  w_idx_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [DATA_W-1:0] pipe_data_r [RD_LAT];
    logic [RD_LAT-1:0] pipe_valid_r;
    logic              err_oob_r;
    logic [CNT_W-1:0]  rd_count_r;
    logic [CNT_W-1:0]  wr_count_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Range decode and the read word sampled before any same-cycle write lands.
    always_comb begin
        r_in_range_s = ({1'b0, vram.vram_r_addr} < (ADDR_W+1)'(DEPTH));
        w_in_range_s = ({1'b0, vram.vram_w_addr} < (ADDR_W+1)'(DEPTH));
        r_idx_s      = vram.vram_r_addr[IDX_W-1:0];
        w_idx_s      = vram.vram_w_addr[IDX_W-1:0];
        rd_word_s    = '0;
        if (vram.vram_r_ena && r_in_range_s) begin
            rd_word_s = mem[r_idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Memory array: masked write, suppressed during reset, contents never cleared.
    always_ff @(posedge clk) begin
        if (!rst && vram.vram_w_ena && w_in_range_s) begin
            mem[w_idx_s] <= (mem[w_idx_s] & ~vram.vram_w_mask)
                          | (vram.vram_w_data & vram.vram_w_mask);
        end
    end

    // Read latency pipeline; idle slots carry zero data so the output is 0 when not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_r[i] <= '0;
            end
        end else begin
            pipe_valid_r[0] <= vram.vram_r_ena;
            pipe_data_r[0]  <= rd_word_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
        end
    end

    // Sticky out-of-range flag and saturating access counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob_r  <= 1'b0;
            rd_count_r <= '0;
            wr_count_r <= '0;
        end else begin
            if ((vram.vram_r_ena && !r_in_range_s) || (vram.vram_w_ena && !w_in_range_s)) begin
                err_oob_r <= 1'b1;
            end
            if (vram.vram_r_ena && r_in_range_s) begin
                rd_count_r <= sat_inc(rd_count_r);
            end
            if (vram.vram_w_ena && w_in_range_s) begin
                wr_count_r <= sat_inc(wr_count_r);
            end
        end
    end

    assign vram.vram_r_valid = pipe_valid_r[RD_LAT-1];
    assign vram.vram_r_data  = pipe_data_r[RD_LAT-1];
    assign err_oob           = err_oob_r;
    assign rd_count          = rd_count_r;
    assign wr_count          = wr_count_r;
endmodule

// File: tb/tb_v_vram_responder.sv
// Drives one shared stimulus stream into three responders (RD_LAT = 1, 2, 3)
// and checks each against a hand-computed vector table shifted by its latency.
module tb_v_vram_responder;
    localparam int DW = 512;
    localparam int AW = 16;
    localparam int CW = 32;
    localparam int NV = 21;

    typedef struct {
        logic          r_ena;
        logic [AW-1:0] r_addr;
        logic          w_ena;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        logic [DW-1:0] w_mask;
        logic          ev;
        logic [DW-1:0] ed;
        logic          cd;
        logic          ee;
        logic [CW-1:0] erc;
        logic [CW-1:0] ewc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic          r_ena = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic          w_ena = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] w_mask = '0;

    logic          err1, err2, err3;
    logic [CW-1:0] rc1, rc2, rc3, wc1, wc2, wc3;

    int total = 0;
    int bad   = 0;
    vec_t tv [NV];

    logic [DW-1:0] ones;
    logic [DW-1:0] low8z;

    always #5 clk = ~clk;

    v_vram_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    v_vram_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();
    v_vram_responder_if #(.DATA_W(DW), .ADDR_W(AW)) if3 ();

    assign if1.vram_r_ena = r_ena;  assign if1.vram_r_addr = r_addr;
    assign if1.vram_w_ena = w_ena;  assign if1.vram_w_addr = w_addr;
    assign if1.vram_w_data = w_data; assign if1.vram_w_mask = w_mask;
    assign if2.vram_r_ena = r_ena;  assign if2.vram_r_addr = r_addr;
    assign if2.vram_w_ena = w_ena;  assign if2.vram_w_addr = w_addr;
    assign if2.vram_w_data = w_data; assign if2.vram_w_mask = w_mask;
    assign if3.vram_r_ena = r_ena;  assign if3.vram_r_addr = r_addr;
    assign if3.vram_w_ena = w_ena;  assign if3.vram_w_addr = w_addr;
    assign if3.vram_w_data = w_data; assign if3.vram_w_mask = w_mask;

    v_vram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .RD_LAT(1), .CNT_W(CW)) u1 (
        .clk(clk), .rst(rst), .vram(if1.slave), .err_oob(err1), .rd_count(rc1), .wr_count(wc1));
    v_vram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .RD_LAT(2), .CNT_W(CW)) u2 (
        .clk(clk), .rst(rst), .vram(if2.slave), .err_oob(err2), .rd_count(rc2), .wr_count(wc2));
    v_vram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .RD_LAT(3), .CNT_W(CW)) u3 (
        .clk(clk), .rst(rst), .vram(if3.slave), .err_oob(err3), .rd_count(rc3), .wr_count(wc3));

    task automatic cmp(input string name, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_inst(input string tag, input int idx,
                            input logic v, input logic [DW-1:0] d, input logic e,
                            input logic [CW-1:0] rc, input logic [CW-1:0] wc,
                            input logic ev, input logic [DW-1:0] ed, input logic cd,
                            input logic ee, input logic [CW-1:0] erc, input logic [CW-1:0] ewc);
        cmp({tag, "_valid"}, idx, DW'(v), DW'(ev));
        if (cd) cmp({tag, "_data"}, idx, d, ev ? ed : '0);
        cmp({tag, "_err"}, idx, DW'(e), DW'(ee));
        cmp({tag, "_rdcnt"}, idx, DW'(rc), DW'(erc));
        cmp({tag, "_wrcnt"}, idx, DW'(wc), DW'(ewc));
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [DW-1:0] ed1, input logic ev1,
                           input logic ee, input logic [CW-1:0] erc, input logic [CW-1:0] ewc);
        chk_inst({tag, "_l1"}, idx, if1.vram_r_valid, if1.vram_r_data, err1, rc1, wc1, ev1, ed1, 1'b1, ee, erc, ewc);
        chk_inst({tag, "_l2"}, idx, if2.vram_r_valid, if2.vram_r_data, err2, rc2, wc2, 1'b0, '0, 1'b1, ee, erc, ewc);
        chk_inst({tag, "_l3"}, idx, if3.vram_r_valid, if3.vram_r_data, err3, rc3, wc3, 1'b0, '0, 1'b1, ee, erc, ewc);
    endtask

    task automatic set_tv(input int i, input logic re, input logic [AW-1:0] ra,
                          input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [DW-1:0] wm, input logic ev, input logic [DW-1:0] ed,
                          input logic cd, input logic ee, input int erc, input int ewc);
        tv[i].r_ena = re;  tv[i].r_addr = ra;
        tv[i].w_ena = we;  tv[i].w_addr = wa;
        tv[i].w_data = wd; tv[i].w_mask = wm;
        tv[i].ev = ev; tv[i].ed = ed; tv[i].cd = cd;
        tv[i].ee = ee; tv[i].erc = CW'(erc); tv[i].ewc = CW'(ewc);
    endtask

    task automatic drive(input logic re, input logic [AW-1:0] ra, input logic we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [DW-1:0] wm);
        r_ena = re; r_addr = ra; w_ena = we; w_addr = wa; w_data = wd; w_mask = wm;
    endtask

    initial begin
        ones  = {DW{1'b1}};
        low8z = {{(DW-8){1'b1}}, 8'h00};

        // Expected outputs below are those of the RD_LAT=1 instance right after the vector's edge.
        //          r  raddr      w  waddr      wdata        wmask         ev  ed           cd  ee rc wc
        set_tv( 0, 1'b1, 16'd0,    1'b0, 16'd0,    '0,          '0,           1'b1, '0,          1'b0, 1'b0, 1, 0);
        set_tv( 1, 1'b0, 16'd0,    1'b1, 16'd5,    ones,        ones,         1'b0, '0,          1'b1, 1'b0, 1, 1);
        set_tv( 2, 1'b0, 16'd0,    1'b1, 16'd5,    '0,          DW'(8'hFF),   1'b0, '0,          1'b1, 1'b0, 1, 2);
        set_tv( 3, 1'b1, 16'd5,    1'b0, 16'd0,    '0,          '0,           1'b1, low8z,       1'b1, 1'b0, 2, 2);
        set_tv( 4, 1'b0, 16'd0,    1'b1, 16'd7,    DW'(16'h1234), ones,       1'b0, '0,          1'b1, 1'b0, 2, 3);
        set_tv( 5, 1'b1, 16'd7,    1'b1, 16'd7,    DW'(16'hABCD), ones,       1'b1, DW'(16'h1234), 1'b1, 1'b0, 3, 4);
        set_tv( 6, 1'b1, 16'd7,    1'b0, 16'd0,    '0,          '0,           1'b1, DW'(16'hABCD), 1'b1, 1'b0, 4, 4);
        set_tv( 7, 1'b0, 16'd0,    1'b1, 16'd1,    DW'(8'h11),  ones,         1'b0, '0,          1'b1, 1'b0, 4, 5);
        set_tv( 8, 1'b0, 16'd0,    1'b1, 16'd2,    DW'(8'h22),  ones,         1'b0, '0,          1'b1, 1'b0, 4, 6);
        set_tv( 9, 1'b0, 16'd0,    1'b1, 16'd3,    DW'(8'h33),  ones,         1'b0, '0,          1'b1, 1'b0, 4, 7);
        set_tv(10, 1'b1, 16'd1,    1'b0, 16'd0,    '0,          '0,           1'b1, DW'(8'h11),  1'b1, 1'b0, 5, 7);
        set_tv(11, 1'b1, 16'd2,    1'b0, 16'd0,    '0,          '0,           1'b1, DW'(8'h22),  1'b1, 1'b0, 6, 7);
        set_tv(12, 1'b1, 16'd3,    1'b0, 16'd0,    '0,          '0,           1'b1, DW'(8'h33),  1'b1, 1'b0, 7, 7);
        set_tv(13, 1'b0, 16'd0,    1'b1, 16'd0,    DW'(8'h5A),  ones,         1'b0, '0,          1'b1, 1'b0, 7, 8);
        set_tv(14, 1'b0, 16'd0,    1'b1, 16'd4096, ones,        ones,         1'b0, '0,          1'b1, 1'b1, 7, 8);
        set_tv(15, 1'b1, 16'hFFFF, 1'b0, 16'd0,    '0,          '0,           1'b1, '0,          1'b1, 1'b1, 7, 8);
        set_tv(16, 1'b1, 16'd0,    1'b0, 16'd0,    '0,          '0,           1'b1, DW'(8'h5A),  1'b1, 1'b1, 8, 8);
        set_tv(17, 1'b1, 16'h1005, 1'b0, 16'd0,    '0,          '0,           1'b1, '0,          1'b1, 1'b1, 8, 8);
        set_tv(18, 1'b0, 16'd0,    1'b0, 16'd0,    '0,          '0,           1'b0, '0,          1'b1, 1'b1, 8, 8);
        set_tv(19, 1'b0, 16'd0,    1'b0, 16'd0,    '0,          '0,           1'b0, '0,          1'b1, 1'b1, 8, 8);
        set_tv(20, 1'b0, 16'd0,    1'b0, 16'd0,    '0,          '0,           1'b0, '0,          1'b1, 1'b1, 8, 8);

        // Reset window with a read held asserted: no response may escape.
        rst = 1'b1;
        drive(1'b1, 16'd0, 1'b0, 16'd0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk_all("rst", c, '0, 1'b0, 1'b0, '0, '0);
        end
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].r_ena, tv[i].r_addr, tv[i].w_ena, tv[i].w_addr, tv[i].w_data, tv[i].w_mask);
            @(posedge clk); #1;
            for (int k = 1; k <= 3; k++) begin
                int j;
                logic ev, cd;
                logic [DW-1:0] ed;
                j = i - (k - 1);
                if (j < 0) begin
                    ev = 1'b0; ed = '0; cd = 1'b1;
                end else begin
                    ev = tv[j].ev; ed = tv[j].ed; cd = tv[j].cd;
                end
                if (k == 1)
                    chk_inst("vec_l1", i, if1.vram_r_valid, if1.vram_r_data, err1, rc1, wc1, ev, ed, cd, tv[i].ee, tv[i].erc, tv[i].ewc);
                else if (k == 2)
                    chk_inst("vec_l2", i, if2.vram_r_valid, if2.vram_r_data, err2, rc2, wc2, ev, ed, cd, tv[i].ee, tv[i].erc, tv[i].ewc);
                else
                    chk_inst("vec_l3", i, if3.vram_r_valid, if3.vram_r_data, err3, rc3, wc3, ev, ed, cd, tv[i].ee, tv[i].erc, tv[i].ewc);
            end
        end

        // Read in flight, then reset next cycle together with a write that must be blocked.
        drive(1'b1, 16'd5, 1'b0, 16'd0, '0, '0);
        @(posedge clk); #1;
        cmp("inflight_l1_data", 0, if1.vram_r_data, low8z);
        rst = 1'b1;
        drive(1'b1, 16'd5, 1'b1, 16'd5, '0, ones);
        @(posedge clk); #1;
        chk_all("midrst", 0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 16'd0, '0, '0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            chk_all("midrst", c, '0, 1'b0, 1'b0, '0, '0);
        end

        // Memory contents survive reset.
        drive(1'b1, 16'd5, 1'b0, 16'd0, '0, '0);
        @(posedge clk); #1;
        chk_inst("keep5_l1", 0, if1.vram_r_valid, if1.vram_r_data, err1, rc1, wc1, 1'b1, low8z, 1'b1, 1'b0, 32'd1, 32'd0);
        drive(1'b1, 16'd0, 1'b0, 16'd0, '0, '0);
        @(posedge clk); #1;
        chk_inst("keep0_l1", 0, if1.vram_r_valid, if1.vram_r_data, err1, rc1, wc1, 1'b1, DW'(8'h5A), 1'b1, 1'b0, 32'd2, 32'd0);
        cmp("keep5_l2_data", 0, if2.vram_r_data, low8z);
        drive(1'b0, 16'd0, 1'b0, 16'd0, '0, '0);
        @(posedge clk); #1;
        cmp("keep5_l3_data", 0, if3.vram_r_data, low8z);
        cmp("keep0_l2_data", 0, if2.vram_r_data, DW'(8'h5A));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/v_vram_responder.md
Name: v_vram_responder

Overview:
- Memory-side responder for the vector unit's VRAM port: accepts the read/write requests issued by the vector core and services them.
- Bit-masked writes; reads return data after a fixed, parameterised latency and are flagged with a valid pulse.
- Also reports out-of-range accesses and keeps saturating access counters for performance bring-up.
- Sits between the vector core top and the testbench/SoC memory image.

Parameters:
- DATA_W, 512, width of one VRAM word (one vector register), bits
- ADDR_W, 16, width of the word address
- DEPTH, 4096, number of implemented words; legal addresses 0..DEPTH-1
- RD_LAT, 1, read latency in cycles, legal 1..4
- CNT_W, 32, width of the access counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- vram_r_ena  in  1  read request this cycle
- vram_r_addr  in  ADDR_W  read word address
- vram_r_data  out  DATA_W  read data, valid when vram_r_valid=1, else 0
- vram_r_valid  out  1  read response strobe
- vram_w_ena  in  1  write request this cycle
- vram_w_addr  in  ADDR_W  write word address
- vram_w_data  in  DATA_W  write data
- vram_w_mask  in  DATA_W  per-bit write enable (1 = update bit)
- err_oob  out  1  sticky out-of-range flag
- rd_count  out  CNT_W  accepted in-range reads, saturating
- wr_count  out  CNT_W  accepted in-range writes, saturating

Behaviour:
- Reset (rst=1 at posedge):
  - vram_r_data=0, vram_r_valid=0, err_oob=0, rd_count=0, wr_count=0.
  - Read pipeline valid bits cleared; in-flight reads are discarded and produce no response.
  - Memory array contents are NOT cleared.
- No back-pressure. Every request is accepted in the cycle it is presented, and one read plus one write may be accepted in the same cycle.
- Write:
  - If vram_w_ena=1 and vram_w_addr<DEPTH, at posedge mem[a] <= (mem[a] & ~mask) | (data & mask).
  - mask=0 is a legal no-op write and still increments wr_count.
- Read:
  - If vram_r_ena=1 at issue cycle T, memory is sampled at T, before any write from the same cycle (read-before-write on address collision).
  - Data enters an RD_LAT-deep shift pipeline with a valid bit.
  - vram_r_valid=1 and vram_r_data=word in cycle T+RD_LAT, i.e. visible after the RD_LAT-th posedge.
  - Back-to-back reads give one response per cycle, in order.
- Read-after-write: a read issued in cycle T+1 or later sees a write accepted at T.
- Out of range (addr >= DEPTH):
  - Write: dropped, memory unchanged, err_oob set, wr_count unchanged.
  - Read: still produces a response at T+RD_LAT with data 0 and vram_r_valid=1; err_oob set; rd_count unchanged.
  - err_oob clears only on rst.
- Counters: increment by 1 per accepted in-range access and hold at 2^CNT_W-1. A simultaneous read and write in one cycle increments both counters.
- Reset is honoured mid-operation: a read issued in the cycle rst=1 is ignored, and rst overrides any write in the same cycle (no memory update).
- Address bits above the log2(DEPTH) implemented bits are checked only through the range comparison; there is no aliasing.

Test Plan:
- Reset, then read addr 0 with RD_LAT=1 -> valid=0 for the whole reset window; valid=1 exactly one cycle after issue; counters read rd=1, wr=0.
- Write addr 5 data=all-ones mask=all-ones; next cycle write addr 5 data=0, mask=0x...00FF; read addr 5 -> data = all-ones with low 8 bits 0; wr_count=2.
- Same-cycle read and write to addr 7 (old word 0x1234, new word 0xABCD): response shows 0x1234; a read in the following cycle returns 0xABCD; rd_count=2, wr_count=1.
- RD_LAT=3, reads to addr 1,2,3 on consecutive cycles, holding words 0x11,0x22,0x33 -> responses 0x11,0x22,0x33 in cycles T+3..T+5, valid low elsewhere.
- Write to addr DEPTH (4096) and read from addr 0xFFFF -> memory unchanged, read response data 0 with valid=1, err_oob=1 and held until rst, counters unchanged.
- Issue a read with RD_LAT=2, then assert rst in the next cycle -> no vram_r_valid pulse ever appears; all outputs 0 after reset; memory still holds its previously written words.
